// File: rtl/dadda_mac_6bit.sv
// Dadda-core multiply-accumulate: LEN 6x6 products summed into a saturating ACC_W accumulator.
// Result visible 3 cycles after the last accept; the result is held until out_ready, with no input accepted meanwhile.

module Dadda_6bit (
  input  logic [5:0]  A,
  input  logic [5:0]  B,
  input  logic        CIN,
  output logic [11:0] result
);

  // 3:2 compressor over whole rows: {carry<<1, sum}
  function automatic logic [23:0] csa(input logic [11:0] x, input logic [11:0] y,
                                      input logic [11:0] z);
    csa = {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
  endfunction

  logic [11:0] pp [6];
  logic [23:0] l1a, l1b, l2, l3;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      pp[i] = {6'b0, A & {6{B[i]}}} << i;
    end
  end

  // Height reduction 6 -> 4 -> 3 -> 2, then one carry-propagate add
  assign l1a    = csa(pp[0], pp[1], pp[2]);
  assign l1b    = csa(pp[3], pp[4], pp[5]);
  assign l2     = csa(l1a[11:0], l1a[23:12], l1b[11:0]);
  assign l3     = csa(l2[11:0], l2[23:12], l1b[23:12]);
  assign result = l3[11:0] + l3[23:12] + {11'b0, CIN};

endmodule

module dadda_mac_6bit #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       a,
  input  logic [5:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [5:0]       a_q, b_q;
  logic             v1, v2;
  logic [11:0]      prod_q, product;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic [ACC_W:0]   sum;

  Dadda_6bit u_mul (
    .A      (a_q),
    .B      (b_q),
    .CIN    (1'b0),
    .result (product)
  );

  assign in_ready  = !rst && (state_q == IDLE || state_q == RUN) && (cnt < LEN_C);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = accept && (cnt + 1'b1 == LEN_C);
  assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last ? DRAIN : RUN;
      RUN:     if (last) state_d = DRAIN;
      // the final product is in S2 once S1 has emptied; it lands on this edge
      DRAIN:   if (!v1) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      v1      <= accept;
      v2      <= v1;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        cnt <= cnt + 1'b1;
      end
      if (v1) prod_q <= product;
      if (state_q == HOLD && out_ready) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        cnt   <= '0;
      end else if (v2) begin
        if (sum[ACC_W]) begin
          acc_q <= '1;
          ovf_q <= 1'b1;
        end else begin
          acc_q <= sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dadda_mac_6bit.sv
// Bench: three MAC instances (LEN/ACC_W = 4/16, 2/12, 1/16) against a transaction-level model
// plus directed vectors with hand-computed sums.

module tb_dadda_mac_6bit;

  localparam int LENS [3] = '{4, 2, 1};
  localparam int MAXS [3] = '{65535, 4095, 65535};

  logic        clk;
  logic [2:0]  rstv, ivv, orv;
  logic [5:0]  av [3];
  logic [5:0]  bv [3];
  logic [2:0]  irv, ovv, ofv;
  logic [15:0] acc0, acc2;
  logic [11:0] acc1;

  int lit_tests = 0, lit_fails = 0;
  int cmp_tests = 0, cmp_fails = 0;

  int m_cnt [3] = '{default: 0};
  int m_sum [3] = '{default: 0};
  int m_cd  [3] = '{default: 0};
  bit m_hold[3] = '{default: 0};
  bit m_ovf [3] = '{default: 0};

  dadda_mac_6bit #(.LEN(4), .ACC_W(16)) u0 (
    .clk(clk), .rst(rstv[0]), .in_valid(ivv[0]), .in_ready(irv[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ovv[0]), .out_ready(orv[0]), .acc_out(acc0), .overflow(ofv[0]));
  dadda_mac_6bit #(.LEN(2), .ACC_W(12)) u1 (
    .clk(clk), .rst(rstv[1]), .in_valid(ivv[1]), .in_ready(irv[1]), .a(av[1]), .b(bv[1]),
    .out_valid(ovv[1]), .out_ready(orv[1]), .acc_out(acc1), .overflow(ofv[1]));
  dadda_mac_6bit #(.LEN(1), .ACC_W(16)) u2 (
    .clk(clk), .rst(rstv[2]), .in_valid(ivv[2]), .in_ready(irv[2]), .a(av[2]), .b(bv[2]),
    .out_valid(ovv[2]), .out_ready(orv[2]), .acc_out(acc2), .overflow(ofv[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int acc_of(input int k);
    case (k)
      0:       return int'(acc0);
      1:       return int'(acc1);
      default: return int'(acc2);
    endcase
  endfunction

  // Model: a dot product's result is the saturating sum of its LEN products,
  // shown two edges after its last accept and held until the output handshake.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rstv[k] || (m_hold[k] && orv[k])) begin
        m_cnt[k] = 0; m_sum[k] = 0; m_cd[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
      end else if (!m_hold[k]) begin
        if (ivv[k] && m_cnt[k] < LENS[k] && m_cd[k] == 0) begin
          m_sum[k] = m_sum[k] + int'(av[k]) * int'(bv[k]);
          if (m_sum[k] > MAXS[k]) begin
            m_sum[k] = MAXS[k];
            m_ovf[k] = 1;
          end
          m_cnt[k]++;
          if (m_cnt[k] == LENS[k]) m_cd[k] = 3;
        end
        if (m_cd[k] > 0) begin
          m_cd[k]--;
          if (m_cd[k] == 0) m_hold[k] = 1;
        end
      end
    end
  end

  task automatic cmp_check(input string name, input int k, input int act, input int exp);
    cmp_tests++;
    if (act !== exp) begin
      cmp_fails++;
      $display("FAIL %s[%0d] @%0t: actual=%0d required=%0d", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      cmp_check("in_ready", k, int'(irv[k]),
                int'(!rstv[k] && !m_hold[k] && m_cnt[k] < LENS[k]));
      cmp_check("out_valid", k, int'(ovv[k]), int'(m_hold[k]));
      if (m_hold[k]) begin
        cmp_check("acc_out", k, acc_of(k), m_sum[k]);
        cmp_check("overflow", k, int'(ofv[k]), int'(m_ovf[k]));
      end
    end
  end

  task automatic lit_check(input string name, input int act, input int exp);
    lit_tests++;
    if (act !== exp) begin
      lit_fails++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int k, input int x, input int y);
    ivv[k] = 1'b1;
    av[k]  = 6'(x);
    bv[k]  = 6'(y);
    step(1);
    ivv[k] = 1'b0;
  endtask

  // Called right after the last accept edge; latency counts further edges until out_valid.
  task automatic wait_out(input int k, input string name, input int exp_acc, input int exp_ovf);
    int n;
    n = 0;
    while (!ovv[k] && n < 20) begin
      step(1);
      n++;
    end
    lit_check({name, "_latency"}, ovv[k] ? n : -1, 2);
    lit_check({name, "_acc"}, acc_of(k), exp_acc);
    lit_check({name, "_ovf"}, int'(ofv[k]), exp_ovf);
  endtask

  task automatic handshake(input int k, input string name);
    step(1);
    lit_check({name, "_valid_after_hs"}, int'(ovv[k]), 0);
    lit_check({name, "_ready_after_hs"}, int'(irv[k]), 1);
  endtask

  initial begin
    rstv = 3'b111; ivv = 3'b000; orv = 3'b111;
    for (int k = 0; k < 3; k++) begin
      av[k] = '0;
      bv[k] = '0;
    end
    step(3);
    lit_check("rst_in_ready", int'(irv), 0);
    lit_check("rst_out_valid", int'(ovv), 0);
    lit_check("rst_acc0", acc_of(0), 0);
    lit_check("rst_overflow", int'(ofv), 0);
    rstv = 3'b000;
    #1;
    lit_check("post_rst_in_ready", int'(irv), 7);

    // back-to-back vector: 1 + 6 + 3969 + 0
    push(0, 1, 1); push(0, 2, 3); push(0, 63, 63); push(0, 0, 5);
    wait_out(0, "b2b", 3976, 0);
    handshake(0, "b2b");

    // two-cycle bubbles between elements
    push(0, 1, 1); step(2); push(0, 2, 3); step(2);
    push(0, 63, 63); step(2); push(0, 0, 5);
    wait_out(0, "bubble", 3976, 0);
    handshake(0, "bubble");

    // backpressure in HOLD with ignored input pulses
    orv[0] = 1'b0;
    push(0, 1, 1); push(0, 2, 3); push(0, 63, 63); push(0, 0, 5);
    wait_out(0, "bp", 3976, 0);
    for (int i = 0; i < 10; i++) begin
      ivv[0] = 1'b1;
      av[0]  = 6'($urandom_range(63));
      bv[0]  = 6'($urandom_range(63));
      step(1);
      lit_check("bp_valid_held", int'(ovv[0]), 1);
      lit_check("bp_acc_stable", acc_of(0), 3976);
      lit_check("bp_in_ready", int'(irv[0]), 0);
    end
    ivv[0] = 1'b0;
    orv[0] = 1'b1;
    handshake(0, "bp");
    push(0, 1, 2); push(0, 1, 2); push(0, 1, 2); push(0, 1, 2);
    wait_out(0, "bp_next", 8, 0);
    handshake(0, "bp_next");

    // saturation at ACC_W=12: 3969 + 3969 clips to 4095
    push(1, 63, 63); push(1, 63, 63);
    wait_out(1, "sat", 4095, 1);
    handshake(1, "sat");
    push(1, 1, 1); push(1, 1, 1);
    wait_out(1, "sat_next", 2, 0);
    handshake(1, "sat_next");

    // reset after two accepts discards the partial vector
    push(0, 3, 3); push(0, 3, 3);
    rstv[0] = 1'b1;
    step(2);
    lit_check("midrst_ready", int'(irv[0]), 0);
    rstv[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      lit_check("midrst_no_output", int'(ovv[0]), 0);
    end
    push(0, 2, 2); push(0, 2, 2); push(0, 2, 2); push(0, 2, 2);
    wait_out(0, "midrst_next", 16, 0);
    handshake(0, "midrst_next");

    // LEN=1: each accept is a complete dot product
    push(2, 5, 7);
    wait_out(2, "len1_a", 35, 0);
    handshake(2, "len1_a");
    push(2, 6, 6);
    wait_out(2, "len1_b", 36, 0);
    handshake(2, "len1_b");

    step(3);
    $display("[TB] %0d tests run, %0d failed", lit_tests + cmp_tests, lit_fails + cmp_fails);
    $finish;
  end

endmodule

// File: doc/dadda_mac_6bit.md
# dadda_mac_6bit

Sequential multiply-accumulate stage built around the combinational `Dadda_6bit` multiplier. It accepts a stream of 6-bit operand pairs over a valid/ready handshake and computes each product in the Dadda core. It accumulates exactly LEN products into a saturating ACC_W-bit sum and presents the dot-product result downstream over a second valid/ready handshake. It is the consumer of the multiplier's `result` and the producer for downstream filter/dot-product logic.

## Interface
- LEN, 4: number of products per dot product; minimum 1.
- ACC_W, 16: accumulator width; minimum 12.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  6  unsigned multiplicand.
- b  in  6  unsigned multiplier.
- out_valid  out  1  dot-product result valid.
- out_ready  in  1  downstream accepts result.
- acc_out  out  ACC_W  accumulated sum, unsigned.
- overflow  out  1  sticky; a saturation occurred in this dot product.

## Operation
- One `Dadda_6bit` instance. `A`/`B` are driven from registered operands, `CIN` is tied 0, and the product is `result[11:0]`. Upper result bits are ignored.
- Pipeline:
  - S1 holds the operand registers a_q, b_q and valid v1.
  - S2 holds the product register prod_q (12 bits) and valid v2.
  - S3 is the accumulator acc_q (ACC_W bits).
- Accept occurs when in_valid & in_ready at a rising edge. a/b are captured into S1, and cnt increments.
- cnt has width clog2(LEN+1). cnt==LEN means all elements are accepted.
- Accumulate rule: when v2=1, sum = acc_q + zero-extended prod_q, computed at ACC_W+1 bits.
  - If sum ≥ 2^ACC_W, acc_q saturates to 2^ACC_W−1 and overflow is set to 1.
  - Otherwise acc_q = sum.
- FSM states:
  - IDLE: acc_q=0, cnt=0, overflow=0, pipeline empty. in_ready=1. The first accept moves to RUN.
  - RUN: in_ready = (cnt<LEN). in_valid may drop at any time, and bubbles propagate as v1/v2=0. When cnt==LEN after an accept, move to DRAIN.
  - DRAIN: in_ready=0. Wait until v1=0 and v2=0 after the final accumulate, then move to HOLD.
  - HOLD: out_valid=1, acc_out=acc_q, overflow stable. in_ready=0. On out_valid & out_ready, clear acc_q, cnt and overflow, and move to IDLE.
- LEN=1: IDLE→RUN→DRAIN happens on the single accept edge, i.e. IDLE goes directly to DRAIN.
- acc_out and overflow are driven from registers. They may change in RUN/DRAIN and must be sampled only when out_valid=1.
- Reset, including mid-operation: at the rst edge, state=IDLE, all valids=0, and acc_q/cnt/overflow/prod_q/operands=0. The partial dot product is discarded with no output.

## Timing
- Reset values: in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts. out_valid=0, acc_out=0, overflow=0.
- Accept at edge E:
  - operands registered at E;
  - product registered at E+1;
  - accumulated at E+2.
- The last accept at edge T gives out_valid=1 after edge T+2. This is 3 cycles from input to visible result when there are no bubbles.
- Back-to-back LEN=4 with accepts at edges 0..3 gives out_valid after edge 5.
- in_ready drops in the cycle after the LEN-th accept. No accept is possible at cnt==LEN.
- out_valid holds with a stable acc_out until the handshake edge. Backpressure has no limit.
- After the output handshake at edge H: out_valid=0 and in_ready=1 after H. A new accept is possible at edge H+1.
- There is no overlap between consecutive dot products.
- Throughput: LEN+3 cycles per result with out_ready tied 1.

## Test plan
- Reset then LEN=4, pairs (1,1),(2,3),(63,63),(0,5) back-to-back, out_ready=1 -> out_valid after 6th edge, acc_out=3976, overflow=0, then in_ready=1 next cycle.
- Bubbles: same 4 pairs with in_valid low for 2 cycles between each -> same acc_out=3976, and out_valid 3 cycles after the last accept.
- Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid stays 1, acc_out stable, in_ready=0, and in_valid pulses ignored. Raising out_ready completes the handshake, and the next vector starts from acc=0.
- Saturation: ACC_W=12, LEN=2, pairs (63,63),(63,63) -> acc_out=4095, overflow=1. The next vector (1,1),(1,1) -> acc_out=2, overflow=0.
- Reset mid-operation: assert rst after 2 accepts of a LEN=4 vector -> out_valid never rises for it. After reset, vector (2,2)×4 -> acc_out=16.
- LEN=1: pairs (5,7) then (6,6) with out_ready=1 -> results 35 then 36, each 3 cycles after its accept.
